// File: rtl/rb_xfer_if.sv
// rtl/rb_xfer_if.sv - control, save/restore stream and register-bank signals of rb_xfer
interface rb_xfer_if #(
   parameter int DW   = 16,
   parameter int NREG = 16,
   parameter int SELW = 4
);
   logic                start;
   logic                mode;
   logic [NREG-1:0]     mask;
   logic                busy;
   logic                done;
   logic [DW-1:0]       sd_out;
   logic                sv_out;
   logic                sr_in;
   logic [DW-1:0]       ld_in;
   logic                lv_in;
   logic                lr_out;
   logic [DW-1:0]       d_out;
   logic                rw_out;
   logic [3*SELW-1:0]   rs_out;
   logic [DW-1:0]       a_in;

   modport master (
      input  start, mode, mask, sr_in, ld_in, lv_in, a_in,
      output busy, done, sd_out, sv_out, lr_out, d_out, rw_out, rs_out
   );

   modport slave (
      output start, mode, mask, sr_in, ld_in, lv_in, a_in,
      input  busy, done, sd_out, sv_out, lr_out, d_out, rw_out, rs_out
   );
endinterface

// File: rtl/rb_xfer.sv
// rtl/rb_xfer.sv - register-bank save/restore sequencer driving the bank d_in/rw_in/rs_in/a_out port
module rb_xfer #(
   parameter int DW   = 16,
   parameter int NREG = 16,
   parameter int SELW = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   rb_xfer_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE, S_FIN} state_e;

   state_e            state_q, state_d;
   logic [NREG-1:0]   rem_q, rem_d;
   logic [DW-1:0]     sd_q, sd_d;
   logic              sv_q, sv_d;
   logic [DW-1:0]     d_q, d_d;
   logic              rw_q, rw_d;
   logic [SELW-1:0]   wsel_q, wsel_d;
   logic [SELW-1:0]   idx;
   logic [SELW-1:0]   asel;
   logic              rem_nz;
   logic              out_free;
   logic              lr;
   logic              accept;

   // Lowest pending register wins, giving ascending visit order.
   always_comb begin : prio_enc
      idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (rem_q[i]) idx = SELW'(i);
      end
   end

   assign rem_nz   = |rem_q;
   assign out_free = !sv_q || bus.sr_in;
   assign lr       = (state_q == S_RESTORE) && rem_nz;
   assign accept   = lr && bus.lv_in;
   assign asel     = ((state_q == S_SAVE) && rem_nz) ? idx : '0;

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         sd_q    <= '0;
         sv_q    <= 1'b0;
         d_q     <= '0;
         rw_q    <= 1'b0;
         wsel_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sd_q    <= sd_d;
         sv_q    <= sv_d;
         d_q     <= d_d;
         rw_q    <= rw_d;
         wsel_q  <= wsel_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      rem_d   = rem_q;
      sd_d    = sd_q;
      sv_d    = sv_q;
      d_d     = d_q;
      rw_d    = 1'b0;
      wsel_d  = wsel_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               rem_d = bus.mask;
               if (bus.mask == '0)  state_d = S_FIN;
               else if (bus.mode)   state_d = S_RESTORE;
               else                 state_d = S_SAVE;
            end
         end
         S_SAVE: begin
            if (out_free && rem_nz) begin
               sd_d       = bus.a_in;
               sv_d       = 1'b1;
               rem_d[idx] = 1'b0;
            end else if (out_free) begin
               sv_d    = 1'b0;
               state_d = S_FIN;
            end
         end
         S_RESTORE: begin
            if (accept) begin
               d_d        = bus.ld_in;
               rw_d       = 1'b1;
               wsel_d     = idx;
               rem_d[idx] = 1'b0;
            end
            // Leave only after the final write has been presented to the bank.
            if (!rem_nz && !rw_q) state_d = S_FIN;
         end
         S_FIN: begin
            sv_d    = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin : out_comb
      bus.busy   = (state_q != S_IDLE);
      bus.done   = (state_q == S_FIN);
      bus.sd_out = sd_q;
      bus.sv_out = sv_q;
      bus.lr_out = lr;
      bus.d_out  = d_q;
      bus.rw_out = rw_q;
      bus.rs_out = {wsel_q, asel, {SELW{1'b0}}};
   end
endmodule

// File: tb/tb_rb_xfer.sv
// tb/tb_rb_xfer.sv - randomized self-checking bench for rb_xfer with a transaction-level model
module tb_rb_xfer;
   localparam int DW   = 16;
   localparam int NREG = 16;
   localparam int SELW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rb_xfer_if #(.DW(DW), .NREG(NREG), .SELW(SELW)) bus ();
   rb_xfer #(.DW(DW), .NREG(NREG), .SELW(SELW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

   // Register bank: combinational A read, write on the edge after rw_out.
   logic [DW-1:0] bank      [NREG];
   logic [DW-1:0] init_bank [NREG];
   logic          load_bank = 1'b0;

   always @(posedge clk) begin
      if (load_bank) begin
         for (int i = 0; i < NREG; i++) bank[i] <= init_bank[i];
      end else if (bus.rw_out) begin
         bank[bus.rs_out[11:8]] <= bus.d_out;
      end
   end
   assign bus.a_in = bank[bus.rs_out[7:4]];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction model: the selected indices in ascending order, words consumed one per handshake.
   int            cyc = 0, s0 = 0, done_at = 0, cnt = 0, nx = 0, ops = 0;
   int            last_lat = 0, last_nx = 0;
   bit            active = 1'b0, m_mode = 1'b0, pend_rw = 1'b0, was_active = 1'b0;
   bit            exp_sv = 1'b0, exp_lr = 1'b0;
   int            idxq [$];
   int            widx [$];
   logic [DW-1:0] wq   [$];
   logic [DW-1:0] mbank [NREG];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("reset_outputs", 64'({bus.busy, bus.done, bus.sv_out, bus.lr_out, bus.rw_out,
                                   bus.sd_out, bus.d_out, bus.rs_out}), 64'd0);
         active  = 1'b0;
         pend_rw = 1'b0;
         idxq.delete(); widx.delete(); wq.delete();
      end else begin
         if (load_bank) mbank = init_bank;
         was_active = active;
         chk("busy", 64'(bus.busy), 64'(active && cyc > s0 && cyc <= done_at));
         chk("done", 64'(bus.done), 64'(active && cyc == done_at));
         chk("rs_b_sel", 64'(bus.rs_out[3:0]), 64'd0);

         exp_sv = active && !m_mode && cyc >= s0 + 2 && idxq.size() > 0;
         chk("sv_out", 64'(bus.sv_out), 64'(exp_sv));
         if (active && !m_mode && cyc > s0 && cyc < done_at)
            chk("rs_a_sel", 64'(bus.rs_out[7:4]),
                64'((cyc == s0 + 1) ? idxq[0] : ((idxq.size() > 1) ? idxq[1] : 0)));
         if (exp_sv) chk("sd_out", 64'(bus.sd_out), 64'(mbank[idxq[0]]));
         if (exp_sv && bus.sr_in) begin
            void'(idxq.pop_front());
            nx++;
            if (idxq.size() == 0) done_at = cyc + 1;
         end

         chk("rw_out", 64'(bus.rw_out), 64'(pend_rw));
         if (pend_rw) begin
            chk("wr_sel", 64'(bus.rs_out[11:8]), 64'(widx[0]));
            chk("d_out", 64'(bus.d_out), 64'(wq[0]));
            mbank[widx[0]] = wq[0];
            void'(widx.pop_front());
            void'(wq.pop_front());
            nx++;
            if (idxq.size() == 0 && widx.size() == 0) done_at = cyc + 2;
         end
         exp_lr = active && m_mode && cyc > s0 && idxq.size() > 0;
         chk("lr_out", 64'(bus.lr_out), 64'(exp_lr));
         pend_rw = exp_lr && (bus.lv_in == 1'b1);
         if (pend_rw) begin
            widx.push_back(idxq.pop_front());
            wq.push_back(bus.ld_in);
         end

         if (active && cyc == done_at) begin
            last_lat = cyc - s0;
            last_nx  = nx;
            chk("xfer_count", 64'(nx), 64'(cnt));
            active = 1'b0;
            ops++;
         end
         if (!was_active && bus.start == 1'b1) begin
            active = 1'b1;
            m_mode = bus.mode;
            s0 = cyc; nx = 0; cnt = 0; pend_rw = 1'b0;
            idxq.delete(); widx.delete(); wq.delete();
            for (int i = 0; i < NREG; i++) begin
               if (bus.mask[i]) begin
                  idxq.push_back(i);
                  cnt++;
               end
            end
            done_at = (cnt == 0) ? cyc + 1 : 32'h3fff_ffff;
         end
      end
   end

   task automatic pulse_load();
      load_bank = 1'b1;
      @(posedge clk); #1;
      load_bank = 1'b0;
   endtask

   task automatic check_bank();
      for (int i = 0; i < NREG; i++) chk($sformatf("bank_r%0d", i), 64'(bank[i]), 64'(mbank[i]));
   endtask

   // pat gives valid/ready per cycle after start (bit k); rst_k >= 0 pulses reset at that cycle.
   task automatic do_op(input bit md, input logic [15:0] mk, input logic [63:0] pat, input bit rnd,
                        input bit bs, input int rst_k, input logic [15:0] dbase);
      int n0;
      int k;
      bit b;
      bit aborted;
      n0 = ops; k = 0; aborted = 1'b0;
      bus.start = 1'b1; bus.mode = md; bus.mask = mk;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (ops == n0 && !aborted && k < 400) begin
         b = rnd ? ($urandom_range(0, 3) != 0) : ((k < 64) ? pat[k[5:0]] : 1'b1);
         bus.lv_in = md & b;
         bus.sr_in = !md & b;
         bus.ld_in = (dbase != 16'd0) ? 16'(dbase + 16'(k)) : 16'($urandom);
         if (bs && k == 2) begin
            bus.start = 1'b1; bus.mask = 16'($urandom); bus.mode = !md;
         end
         if (bs && k == 3) bus.start = 1'b0;
         if (rst_k >= 0 && k == rst_k) rst_n = 1'b0;
         if (rst_k >= 0 && k == rst_k + 2) begin
            rst_n   = 1'b1;
            aborted = 1'b1;
         end else begin
            @(posedge clk); #1;
            k++;
         end
      end
      bus.start = 1'b0; bus.lv_in = 1'b0; bus.sr_in = 1'b0;
      if (!aborted) begin
         chk("op_completes", 64'(ops != n0), 64'd1);
         if (ops == n0) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] mk;
      bit          md;
      int          r;
      bus.start = 1'b0; bus.mode = 1'b0; bus.mask = '0;
      bus.sr_in = 1'b0; bus.ld_in = '0;  bus.lv_in = 1'b0;
      for (int i = 0; i < NREG; i++) init_bank[i] = 16'(32'h5A00 + i);
      init_bank[0] = 16'h1111;
      init_bank[2] = 16'h2222;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      pulse_load();

      do_op(1'b0, 16'h0005, '1, 1'b0, 1'b0, -1, 16'h0);
      chk("save_0005_latency", 64'(last_lat), 64'd4);
      chk("save_0005_count", 64'(last_nx), 64'd2);
      check_bank();

      do_op(1'b0, 16'h8001, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b1, -1, 16'h0);
      chk("save_8001_latency", 64'(last_lat), 64'd7);
      chk("save_8001_count", 64'(last_nx), 64'd2);

      do_op(1'b1, 16'h00F0, '1, 1'b0, 1'b0, -1, 16'h00A0);
      chk("restore_00f0_latency", 64'(last_lat), 64'd7);
      chk("restore_00f0_count", 64'(last_nx), 64'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("restore_00f0_r%0d", 4 + i), 64'(bank[4 + i]), 64'(16'h00A0 + i));
      check_bank();

      do_op(1'b1, 16'h0003, 64'h5555_5555_5555_5555, 1'b0, 1'b1, -1, 16'hC000);
      chk("restore_0003_latency", 64'(last_lat), 64'd6);
      chk("restore_0003_count", 64'(last_nx), 64'd2);
      chk("restore_0003_r0", 64'(bank[0]), 64'h0000_C000);
      chk("restore_0003_r1", 64'(bank[1]), 64'h0000_C002);
      check_bank();

      do_op(1'b0, 16'h0000, '1, 1'b0, 1'b0, -1, 16'h0);
      chk("save_empty_latency", 64'(last_lat), 64'd1);
      chk("save_empty_count", 64'(last_nx), 64'd0);
      do_op(1'b1, 16'h0000, '1, 1'b0, 1'b0, -1, 16'h0);
      chk("restore_empty_latency", 64'(last_lat), 64'd1);

      do_op(1'b0, 16'hFFFF, '1, 1'b0, 1'b0, -1, 16'h0);
      chk("save_ffff_latency", 64'(last_lat), 64'd18);
      chk("save_ffff_count", 64'(last_nx), 64'd16);
      do_op(1'b1, 16'hFFFF, '1, 1'b0, 1'b0, -1, 16'h3000);
      chk("restore_ffff_latency", 64'(last_lat), 64'd19);
      for (int i = 0; i < NREG; i++) chk($sformatf("restore_ffff_r%0d", i), 64'(bank[i]), 64'(16'h3000 + i));

      pulse_load();
      do_op(1'b1, 16'h0007, 64'h1, 1'b0, 1'b0, 3, 16'hBEE0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_r0_written", 64'(bank[0]), 64'h0000_BEE0);
      chk("abort_r1_kept", 64'(bank[1]), 64'h0000_5A01);
      chk("abort_r2_kept", 64'(bank[2]), 64'h0000_2222);
      check_bank();

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NREG; i++) init_bank[i] = 16'($urandom);
         pulse_load();
         r = $urandom_range(0, 7);
         if (r == 0)      mk = 16'h0000;
         else if (r <= 2) mk = 16'(1 << $urandom_range(0, 15));
         else if (r == 3) mk = 16'hFFFF;
         else             mk = 16'($urandom);
         md = ($urandom_range(0, 1) == 1);
         do_op(md, mk, '0, 1'b1, 1'b0, -1, 16'h0);
         check_bank();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/rb_xfer.md
Name: rb_xfer

Overview:
- Register-bank access sequencer: the initiator side of the register-bank d_in/rw_in/rs_in/a_out interface.
- Given a 16-bit register mask, it either reads the selected registers out over a valid/ready stream (SAVE), or writes stream data into them (RESTORE).
- Registers are visited in ascending index order.
- Used for context save/restore and debug dump; sits beside the CPU datapath, which yields the bank while busy=1.

Parameters:
DW, 16, register data width
NREG, 16, number of registers (mask width)
SELW, 4, register select width (log2 NREG)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation (sampled in IDLE only)
mode  in  1  0=SAVE, 1=RESTORE
mask  in  NREG  registers to transfer, bit i = register i
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
sd_out  out  DW  SAVE stream data
sv_out  out  1  SAVE stream valid
sr_in  in  1  SAVE stream ready
ld_in  in  DW  RESTORE stream data
lv_in  in  1  RESTORE stream valid
lr_out  out  1  RESTORE stream ready
d_out  out  DW  to register bank d_in
rw_out  out  1  to register bank rw_in (write enable)
rs_out  out  3*SELW  to register bank rs_in: [11:8] write select, [7:4] A select, [3:0] B select
a_in  in  DW  from register bank a_out (combinational read of A select)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, remaining mask=0; busy, done, sv_out, lr_out, rw_out = 0; sd_out, d_out, rs_out = 0.
- States: IDLE, SAVE, RESTORE, FIN.
- IDLE:
  - start=1 latches mask into rem and goes to SAVE (mode=0) or RESTORE (mode=1).
  - mask=0 goes directly to FIN.
  - start is ignored outside IDLE.
- busy=1 in every state except IDLE.
- idx = lowest set bit of rem (combinational priority encode); B select field is always 0.

SAVE:
- rs_out A field = idx whenever rem!=0; rw_out=0 throughout.
- Output register (sd_out, sv_out) loads when sv_out=0 or sr_in=1, and rem!=0:
  - sd_out<=a_in, sv_out<=1, clear bit idx in rem.
  - First sv_out is asserted 1 cycle after start; full throughput is 1 word/cycle with sr_in held 1.
- sv_out && !sr_in: sd_out and sv_out are held stable (no data change while valid).
- rem=0 and (sv_out=0 or sr_in=1): sv_out<=0, go to FIN.

RESTORE:
- lr_out = 1 while in RESTORE and rem!=0 (combinational from state/rem).
- lv_in && lr_out on a clock edge, registered for one cycle:
  - d_out<=ld_in, rw_out<=1, rs_out write field<=idx, clear bit idx.
- The bank write lands on the following edge; otherwise rw_out<=0.
- rem=0 and rw_out=0 (last write issued): go to FIN.

FIN:
- done=1 for exactly one cycle, then return to IDLE.
- In the FIN cycle, rw_out=0 and sv_out=0.

Boundary conditions:
- mask=16'hFFFF visits indices 0..15 in order.
- A single-bit mask produces exactly one transfer.
- Bubbles (lv_in=0 or sr_in=0) stall without losing or duplicating data.
- rst_n low mid-operation: abort immediately to reset values; no partial write after deassertion.
- sd_out, rs_out, and d_out are never X while their qualifying valid/enable is 1.

Test Plan:
- SAVE, mask=16'h0005, sr_in=1, bank r0=16'h1111, r2=16'h2222 -> sv_out on cycles 1-2 with sd_out 1111 then 2222; done at cycle 3; rw_out never 1.
- SAVE, mask=16'h8001, sr_in held 0 for 3 cycles after first valid -> sd_out=r0 stable 3 cycles, then r15; exactly 2 handshakes.
- RESTORE, mask=16'h00F0, lv_in=1 continuous, ld_in=A0..A3 -> rw_out 4 consecutive cycles, write selects 4,5,6,7, d_out A0..A3; bank r4..r7 match; done after last write.
- RESTORE with lv_in toggling 1,0,1,0 and mask=16'h0003 -> exactly 2 writes (r0, r1), lr_out drops after second accept.
- start with mask=0 (either mode) -> done pulse one cycle after start, no sv_out/rw_out; start asserted while busy -> ignored, mask unchanged.
- rst_n asserted mid-RESTORE after 1 of 3 writes -> outputs zero immediately; after release, busy=0, no further rw_out; only the first register modified.
